spi_flash_resp: RTL and testbench
=================================

// Module: spi_flash_resp
// PURPOSE
// SPI mode-0 flash-style responder: the target end of the SPI bus driven by the AXI-to-SPI
// master bridge. Decodes serial commands and serves reads/programs from an internal byte
// memory. Used as the device model in bridge system sims and as a synthesizable FPGA target.
// All SPI pins are oversampled in the single aclk domain; no SPI-clocked logic.
// PARAMETERS
// MEM_AW       12     byte-address width of internal memory (depth 2**MEM_AW)
// PROG_CYCLES  64     aclk cycles WIP stays set after a page program ends
// JEDEC_ID     24'hEF4012  value returned by RDID
// PORTS
// aclk       in   1  clock; every flop in the block is clocked by it
// areset     in   1  asynchronous, active-high reset
// spi_sck    in   1  serial clock from master (async; sck <= aclk/8)
// spi_csn    in   1  chip select, active low (async)
// spi_mosi   in   1  master-out data (async)
// spi_miso   out  1  slave-out data
// spi_miso_en out 1  output enable for spi_miso pad
// busy       out  1  WIP status mirror
// BEHAVIOUR
// - Reset: spi_miso=0, spi_miso_en=0, busy=0, WEL=0, WIP=0, FSM=IDLE. Memory not reset.
// - Sync: sck/csn/mosi pass 2-flop synchronizers; edges from a 3rd stage. Rise = sample mosi,
//   fall = update miso; spi_miso changes 3 aclk after the pin edge. MSB first, 8-bit bytes.
// - csn fall -> CMD, bit count 0. csn rise in any state -> IDLE next cycle, miso_en=0,
//   partial byte discarded; rise also applies the WREN/PP side effects below.
// - FSM: IDLE, CMD, ADDR, RD, PP, RDSR, RDID, IGNORE. Byte complete = 8th sampled rise.
// - CMD byte decode: 03 READ->ADDR; 02 PP->ADDR if WEL=1 and WIP=0, else IGNORE;
//   06 WREN, 04 WRDI -> IGNORE (take effect on csn rise, only if exactly 8 bits received);
//   05 ->RDSR; 9F ->RDID; any other -> IGNORE. IGNORE: miso_en=0 until csn rise.
// - ADDR: 3 bytes, 24-bit addr; low MEM_AW bits kept, upper bits ignored.
// - RD: on the rise completing the last address bit (and each later byte's 8th rise),
//   load tx shift reg with mem[addr], addr=addr+1 mod 2**MEM_AW (wraps to 0).
//   Each fall: spi_miso=tx[7], shift left. miso_en=1 from the first fall after entry
//   to csn rise. Read is unlimited in length.
// - PP: each completed data byte written to mem[addr] in the following aclk (overwrite).
//   addr[7:0] increments, addr[MEM_AW-1:8] is held (wrap within 256-byte page).
//   csn rise after >=1 byte written: WIP=1 for PROG_CYCLES aclk, WEL=0.
//   PP with zero data bytes: WEL=0, WIP unchanged.
// - RDSR: streams {6'b0, WEL, WIP} repeatedly, value re-latched at each byte start.
//   RDID: streams JEDEC_ID MSB byte first, then repeats 3 bytes.
// - While WIP=1: READ, RDSR, RDID served normally; PP/WREN ignored. busy = WIP.
// - Simultaneous csn rise and sck edge in the same synchronized cycle: csn wins,
//   the edge is dropped.
// - areset mid-transfer: immediate IDLE, miso_en=0, WEL/WIP cleared, memory kept.
//   The transfer stays ignored until the next csn fall.
// TESTING
// 1 WREN (06) then PP 02 00 01 FE + AA 55 -> mem[0x1FE]=AA, mem[0x1FF]=55;
//   busy high for exactly 64 aclk after csn rise; RDSR reads 0x00 after.
// 2 READ 03 00 01 FE, 4 bytes -> AA 55 xx xx; miso_en low before first fall, high
//   through last byte, low 1 aclk after csn rise.
// 3 PP at 0x0FF with 3 bytes 11 22 33 -> mem[0x0FF]=11, mem[0x000]=22, mem[0x001]=33
//   (page wrap). READ at 0xFFF for 2 bytes -> mem[0xFFF], mem[0x000] (array wrap).
// 4 PP without WREN -> memory unchanged; RDSR returns 0x00. WREN then RDSR -> 0x02.
//   WREN then PP during WIP -> ignored.
// 5 9F, 6 bytes -> EF 40 12 EF 40 12; unknown opcode AB -> miso_en stays 0.
// 6 csn rise after 5 bits of PP data -> byte not written. areset pulse mid-READ ->
//   miso_en=0 next cycle, WEL=0; the next transaction decodes correctly.

Source files
------------

// File: rtl/spi_flash_resp.sv
// SPI mode-0 flash-style responder serving READ/PP/RDSR/RDID from an internal byte memory.
// The SPI pins are oversampled in the aclk domain; nothing is clocked by spi_sck.
module spi_flash_resp #(
    parameter int          MEM_AW      = 12,
    parameter int          PROG_CYCLES = 64,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4012
) (
    input  logic aclk,
    input  logic areset,
    input  logic spi_sck,
    input  logic spi_csn,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_en,
    output logic busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_RD     = 3'd3;
    localparam logic [2:0] ST_PP     = 3'd4;
    localparam logic [2:0] ST_RDSR   = 3'd5;
    localparam logic [2:0] ST_RDID   = 3'd6;
    localparam logic [2:0] ST_IGNORE = 3'd7;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_RDID = 8'h9F;

    localparam int             WCW      = $clog2(PROG_CYCLES + 1);
    localparam logic [WCW-1:0] WIP_LOAD = WCW'(PROG_CYCLES - 1);

    logic [2:0]        sck_sync_q;
    logic [2:0]        csn_sync_q;
    logic [1:0]        mosi_sync_q;

    logic [2:0]        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [1:0]        addr_byte_cnt_q, addr_byte_cnt_d;
    logic [1:0]        rdid_idx_q, rdid_idx_d;
    logic              wel_q, wel_d;
    logic              wip_q, wip_d;
    logic [WCW-1:0]    wip_cnt_q, wip_cnt_d;
    logic              miso_q, miso_d;
    logic              miso_en_q, miso_en_d;
    logic              extra_q, extra_d;
    logic              pp_written_q, pp_written_d;

    logic [7:0]        mem_q [0:(1<<MEM_AW)-1];

    logic              sck_rise, sck_fall, csn_rise, csn_fall, mosi_bit;
    logic              byte_done, mem_we;
    logic [7:0]        rx_byte, status_byte, jedec_byte, rd_data;
    logic [MEM_AW-1:0] addr_shift, addr_page_inc, rd_addr;

    // csn stages reset to "selected" so a reset taken mid-transfer cannot
    // fabricate a csn fall; only a real high-then-low starts a command.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sck_sync_q  <= 3'b000;
            csn_sync_q  <= 3'b000;
            mosi_sync_q <= 2'b00;
        end else begin
            sck_sync_q  <= {sck_sync_q[1:0], spi_sck};
            csn_sync_q  <= {csn_sync_q[1:0], spi_csn};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
        end
    end

    assign sck_rise  =  sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall  = ~sck_sync_q[1] &  sck_sync_q[2];
    assign csn_rise  =  csn_sync_q[1] & ~csn_sync_q[2];
    assign csn_fall  = ~csn_sync_q[1] &  csn_sync_q[2];
    assign mosi_bit  =  mosi_sync_q[1];

    assign rx_byte       = {rx_q, mosi_bit};
    assign byte_done     = sck_rise && (bit_cnt_q == 3'd7);
    assign status_byte   = {6'b000000, wel_q, wip_q};
    assign addr_shift    = {addr_q[MEM_AW-2:0], mosi_bit};
    assign addr_page_inc = {addr_q[MEM_AW-1:8], addr_q[7:0] + 8'd1};
    assign rd_addr       = (state_q == ST_ADDR) ? addr_shift : addr_q;
    assign rd_data       = mem_q[rd_addr];

    always_comb begin
        case (rdid_idx_q)
            2'd0:    jedec_byte = JEDEC_ID[23:16];
            2'd1:    jedec_byte = JEDEC_ID[15:8];
            default: jedec_byte = JEDEC_ID[7:0];
        endcase
    end

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        rx_d            = rx_q;
        tx_d            = tx_q;
        cmd_d           = cmd_q;
        addr_d          = addr_q;
        addr_byte_cnt_d = addr_byte_cnt_q;
        rdid_idx_d      = rdid_idx_q;
        wel_d           = wel_q;
        wip_d           = wip_q;
        wip_cnt_d       = wip_cnt_q;
        miso_d          = miso_q;
        miso_en_d       = miso_en_q;
        extra_d         = extra_q;
        pp_written_d    = pp_written_q;
        mem_we          = 1'b0;

        if (wip_q) begin
            if (wip_cnt_q == '0) begin
                wip_d = 1'b0;
            end else begin
                wip_cnt_d = wip_cnt_q - WCW'(1);
            end
        end

        // csn rise outranks any sck edge seen in the same cycle.
        if (csn_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            miso_en_d = 1'b0;
            case (state_q)
                ST_IGNORE: begin
                    if (!extra_q && (cmd_q == OP_WREN) && !wip_q) begin
                        wel_d = 1'b1;
                    end else if (!extra_q && (cmd_q == OP_WRDI)) begin
                        wel_d = 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (cmd_q == OP_PP) begin
                        wel_d = 1'b0;
                    end
                end
                ST_PP: begin
                    wel_d = 1'b0;
                    if (pp_written_q) begin
                        wip_d     = 1'b1;
                        wip_cnt_d = WIP_LOAD;
                    end
                end
                default: ;
            endcase
        end else if (csn_fall) begin
            state_d         = ST_CMD;
            bit_cnt_d       = 3'd0;
            addr_byte_cnt_d = 2'd0;
            extra_d         = 1'b0;
            pp_written_d    = 1'b0;
            miso_en_d       = 1'b0;
        end else if (state_q != ST_IDLE) begin
            if (sck_rise) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                rx_d      = rx_byte[6:0];
            end
            if (sck_fall && ((state_q == ST_RD) || (state_q == ST_RDSR) ||
                             (state_q == ST_RDID))) begin
                miso_d    = tx_q[7];
                tx_d      = {tx_q[6:0], 1'b0};
                miso_en_d = 1'b1;
            end
            case (state_q)
                ST_CMD: begin
                    if (byte_done) begin
                        cmd_d = rx_byte;
                        case (rx_byte)
                            OP_READ: state_d = ST_ADDR;
                            OP_PP:   state_d = (wel_q && !wip_q) ? ST_ADDR : ST_IGNORE;
                            OP_RDSR: begin
                                state_d = ST_RDSR;
                                tx_d    = status_byte;
                            end
                            OP_RDID: begin
                                state_d    = ST_RDID;
                                tx_d       = JEDEC_ID[23:16];
                                rdid_idx_d = 2'd1;
                            end
                            default: state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        addr_d = addr_shift;
                    end
                    if (byte_done) begin
                        addr_byte_cnt_d = addr_byte_cnt_q + 2'd1;
                        if (addr_byte_cnt_q == 2'd2) begin
                            if (cmd_q == OP_READ) begin
                                state_d = ST_RD;
                                tx_d    = rd_data;
                                addr_d  = addr_shift + MEM_AW'(1);
                            end else begin
                                state_d = ST_PP;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (byte_done) begin
                        tx_d   = rd_data;
                        addr_d = addr_q + MEM_AW'(1);
                    end
                end
                ST_PP: begin
                    if (byte_done) begin
                        mem_we       = 1'b1;
                        addr_d       = addr_page_inc;
                        pp_written_d = 1'b1;
                    end
                end
                ST_RDSR: begin
                    if (byte_done) begin
                        tx_d = status_byte;
                    end
                end
                ST_RDID: begin
                    if (byte_done) begin
                        tx_d       = jedec_byte;
                        rdid_idx_d = (rdid_idx_q == 2'd2) ? 2'd0 : rdid_idx_q + 2'd1;
                    end
                end
                ST_IGNORE: begin
                    if (sck_rise) begin
                        extra_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= 3'd0;
            rx_q            <= 7'd0;
            tx_q            <= 8'd0;
            cmd_q           <= 8'd0;
            addr_q          <= '0;
            addr_byte_cnt_q <= 2'd0;
            rdid_idx_q      <= 2'd0;
            wel_q           <= 1'b0;
            wip_q           <= 1'b0;
            wip_cnt_q       <= '0;
            miso_q          <= 1'b0;
            miso_en_q       <= 1'b0;
            extra_q         <= 1'b0;
            pp_written_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            rx_q            <= rx_d;
            tx_q            <= tx_d;
            cmd_q           <= cmd_d;
            addr_q          <= addr_d;
            addr_byte_cnt_q <= addr_byte_cnt_d;
            rdid_idx_q      <= rdid_idx_d;
            wel_q           <= wel_d;
            wip_q           <= wip_d;
            wip_cnt_q       <= wip_cnt_d;
            miso_q          <= miso_d;
            miso_en_q       <= miso_en_d;
            extra_q         <= extra_d;
            pp_written_q    <= pp_written_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            mem_q[addr_q] <= rx_byte;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_en = miso_en_q;
    assign busy        = wip_q;

endmodule

// File: tb/tb_spi_flash_resp.sv
// Directed bench for spi_flash_resp: a default-parameter instance plus a long-WIP
// instance on the same SPI pins, so commands can be issued while WIP is still set.
module tb_spi_flash_resp;

    localparam int HALF      = 8;
    localparam int LONG_PROG = 3000;

    logic aclk     = 1'b0;
    logic areset   = 1'b1;
    logic spi_sck  = 1'b0;
    logic spi_csn  = 1'b1;
    logic spi_mosi = 1'b0;
    logic sel_long = 1'b0;

    logic miso_s, en_s, busy_s;
    logic miso_l, en_l, busy_l;
    logic miso_m, en_m;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_b;
    logic       en_all_b, en_any_b;

    always #5 aclk = ~aclk;

    assign miso_m = sel_long ? miso_l : miso_s;
    assign en_m   = sel_long ? en_l   : en_s;

    spi_flash_resp dut (
        .aclk        (aclk),
        .areset      (areset),
        .spi_sck     (spi_sck),
        .spi_csn     (spi_csn),
        .spi_mosi    (spi_mosi),
        .spi_miso    (miso_s),
        .spi_miso_en (en_s),
        .busy        (busy_s)
    );

    spi_flash_resp #(.PROG_CYCLES(LONG_PROG)) dut_long (
        .aclk        (aclk),
        .areset      (areset),
        .spi_sck     (spi_sck),
        .spi_csn     (spi_csn),
        .spi_mosi    (spi_mosi),
        .spi_miso    (miso_l),
        .spi_miso_en (en_l),
        .busy        (busy_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    // Mode 0: mosi changes while sck is low, miso is sampled at the rising edge.
    task automatic xfer_bits(input logic [7:0] tx, input int nbits);
        rx_b     = 8'h00;
        en_all_b = 1'b1;
        en_any_b = 1'b0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            tick(HALF);
            spi_sck  = 1'b1;
            rx_b[i]  = miso_m;
            en_all_b = en_all_b & en_m;
            en_any_b = en_any_b | en_m;
            tick(HALF);
            spi_sck  = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        xfer_bits(b, 8);
    endtask

    task automatic send3(input logic [23:0] a);
        send(a[23:16]);
        send(a[15:8]);
        send(a[7:0]);
    endtask

    task automatic recv(input string tag, input int n);
        logic [7:0] e;
        for (int k = 0; k < n; k++) begin
            xfer_bits(8'h00, 8);
            e = exp_q.pop_front();
            check(tag, rx_b, e);
        end
    endtask

    task automatic cs_low();
        spi_csn = 1'b0;
        tick(HALF);
    endtask

    task automatic end_txn();
        tick(HALF);
        spi_csn = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic wren();
        cs_low();
        send(8'h06);
        end_txn();
    endtask

    task automatic pp(input logic [23:0] a, input logic [23:0] d, input int n);
        cs_low();
        send(8'h02);
        send3(a);
        for (int k = 0; k < n; k++) send(d[23 - 8 * k -: 8]);
        end_txn();
    endtask

    task automatic read(input string tag, input logic [23:0] a, input int n);
        cs_low();
        send(8'h03);
        send3(a);
        recv(tag, n);
        end_txn();
    endtask

    task automatic rdsr(input string tag, input logic [7:0] e);
        cs_low();
        send(8'h05);
        exp_q.push_back(e);
        exp_q.push_back(e);
        recv(tag, 2);
        end_txn();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_s || busy_l) && n < 4000) begin
            tick(1);
            n++;
        end
        check("busy_clear", {busy_s, busy_l}, 2'b00);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        tick(5);
        check("rst_miso", miso_s, 1'b0);
        check("rst_en", en_s, 1'b0);
        check("rst_busy", busy_s, 1'b0);
        areset = 1'b0;
        tick(8);

        // WREN + page program, exact WIP length, status afterwards
        wren();
        cs_low();
        send(8'h02);
        send3(24'h0001FE);
        send(8'hAA);
        send(8'h55);
        tick(HALF);
        spi_csn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (busy_s) cnt++;
        end
        check("t1_busy_len", cnt, 64);
        rdsr("t1_sr", 8'h00);
        wait_idle();

        // READ with output-enable timing
        cs_low();
        send(8'h03);
        send3(24'h0001FE);
        check("t2_en_pre", en_any_b, 1'b0);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        recv("t2_rd0", 1);
        check("t2_en_b0", en_all_b, 1'b1);
        recv("t2_rd1", 1);
        xfer_bits(8'h00, 8);
        xfer_bits(8'h00, 8);
        check("t2_en_b3", en_all_b, 1'b1);
        tick(HALF);
        spi_csn = 1'b1;
        tick(2);
        check("t2_en_hold", en_s, 1'b1);
        tick(1);
        check("t2_en_off", en_s, 1'b0);
        tick(2 * HALF);
        exp_q.push_back(8'hAA);
        read("t2_hi_addr", 24'h7FF1FE, 1);

        // page wrap on program, array wrap on read
        wren();
        pp(24'h0000FF, 24'h112233, 3);
        wait_idle();
        wren();
        pp(24'h000FFF, 24'h5A0000, 1);
        wait_idle();
        exp_q.push_back(8'h11);
        read("t3_pg_ff", 24'h0000FF, 1);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        read("t3_wrap", 24'h000FFF, 3);

        // write protection and WIP gating
        pp(24'h0001FE, 24'h000000, 1);
        check("t4_nowel_busy", busy_s, 1'b0);
        exp_q.push_back(8'hAA);
        read("t4_nowel_mem", 24'h0001FE, 1);
        rdsr("t4_sr0", 8'h00);
        wren();
        rdsr("t4_sr_wel", 8'h02);
        pp(24'h000300, 24'h990000, 1);
        sel_long = 1'b1;
        wren();
        pp(24'h000300, 24'h980000, 1);
        rdsr("t4_sr_wip", 8'h01);
        wait_idle();
        exp_q.push_back(8'h99);
        read("t4_wip_pp", 24'h000300, 1);
        rdsr("t4_sr_after", 8'h00);
        sel_long = 1'b0;

        // RDID stream and unknown opcode
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(8'hEF);
            exp_q.push_back(8'h40);
            exp_q.push_back(8'h12);
        end
        cs_low();
        send(8'h9F);
        recv("t5_rdid", 6);
        end_txn();
        cs_low();
        send(8'hAB);
        xfer_bits(8'h00, 8);
        check("t5_unk_en0", en_any_b, 1'b0);
        xfer_bits(8'h00, 8);
        check("t5_unk_en1", en_any_b, 1'b0);
        end_txn();

        // partial data byte, over-long WREN, reset mid-READ
        wren();
        pp(24'h000400, 24'h3C0000, 1);
        wait_idle();
        wren();
        cs_low();
        send(8'h02);
        send3(24'h000400);
        xfer_bits(8'hC3, 5);
        end_txn();
        check("t6_part_busy", busy_s, 1'b0);
        exp_q.push_back(8'h3C);
        read("t6_part_mem", 24'h000400, 1);
        rdsr("t6_part_sr", 8'h00);
        cs_low();
        send(8'h06);
        xfer_bits(8'h00, 1);
        end_txn();
        rdsr("t6_wren9_sr", 8'h00);

        wren();
        cs_low();
        send(8'h03);
        send3(24'h0001FE);
        exp_q.push_back(8'hAA);
        recv("t6_rd_pre", 1);
        areset = 1'b1;
        #1;
        check("t6_rst_en", en_s, 1'b0);
        tick(1);
        check("t6_rst_busy", busy_s, 1'b0);
        areset = 1'b0;
        tick(2);
        xfer_bits(8'h00, 8);
        check("t6_post_rst_en", en_any_b, 1'b0);
        end_txn();
        rdsr("t6_rst_wel", 8'h00);
        exp_q.push_back(8'h55);
        read("t6_next_rd", 24'h0001FF, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
